// File: rtl/escalonador_processos.sv
// escalonador_processos: round-robin context-switch controller.
// Saves the interrupted PC into a process table, picks the next ready process
// and issues its PC to the PC register. The OS loads entries via req/ack.
//
// Ports:
//   clock, reset (async, active-low)
//   troca_contexto, pc_processo_trocado, fimProcesso   : switch/finish events
//   carregar_req, carregar_pid, carregar_pc_in, carregar_ack : table load port
//   pc_novo, carregar_pc, processo_atual, sem_processo, ocupado : dispatch outputs
//   total_trocas (only with ESCALONADOR_CONTA_TROCAS_EN) : saturating dispatch count
//
// Optional feature macro: ESCALONADOR_CONTA_TROCAS_EN
module escalonador_processos #(
    parameter int unsigned          NUM_PROC = 4,
    parameter int unsigned          PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]  SO_PC    = '0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          troca_contexto,
    input  logic [PC_WIDTH-1:0]           pc_processo_trocado,
    input  logic                          fimProcesso,
    input  logic                          carregar_req,
    input  logic [$clog2(NUM_PROC)-1:0]   carregar_pid,
    input  logic [PC_WIDTH-1:0]           carregar_pc_in,
    output logic                          carregar_ack,
    output logic [PC_WIDTH-1:0]           pc_novo,
    output logic                          carregar_pc,
    output logic [$clog2(NUM_PROC)-1:0]   processo_atual,
    output logic                          sem_processo,
    output logic                          ocupado
`ifdef ESCALONADOR_CONTA_TROCAS_EN
    ,
    output logic [31:0]                   total_trocas
`endif
);

    localparam int unsigned IDX_W = $clog2(NUM_PROC);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SALVA   = 2'd1,
        BUSCA   = 2'd2,
        CARREGA = 2'd3
    } estado_t;

    estado_t                estado_q, estado_d;
    logic                   troca_q, fim_q;
    logic                   eh_fim_q, eh_fim_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [IDX_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       sel_q, sel_d;
    logic                   achou_q, achou_d;
    logic [NUM_PROC-1:0]    valid_q, valid_d;
    logic [PC_WIDTH-1:0]    pc_tab_q [NUM_PROC];
    logic [PC_WIDTH-1:0]    pc_tab_d [NUM_PROC];
    logic [PC_WIDTH-1:0]    pc_novo_q, pc_novo_d;
    logic                   carregar_pc_q, carregar_pc_d;
    logic                   ack_q, ack_d;
    logic [IDX_W-1:0]       atual_q, atual_d;
    logic                   sem_q, sem_d;
    logic                   ocupado_q, ocupado_d;
`ifdef ESCALONADOR_CONTA_TROCAS_EN
    logic [31:0]            trocas_q, trocas_d;
`endif

    logic troca_sobe, fim_sobe, evento;

    // Rising-edge detection; held levels do not retrigger
    assign troca_sobe = troca_contexto & ~troca_q;
    assign fim_sobe   = fimProcesso & ~fim_q;
    assign evento     = troca_sobe | fim_sobe;

    // Next-state and table update logic
    always_comb begin
        estado_d      = estado_q;
        eh_fim_d      = eh_fim_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        sel_d         = sel_q;
        achou_d       = achou_q;
        valid_d       = valid_q;
        pc_tab_d      = pc_tab_q;
        pc_novo_d     = pc_novo_q;
        carregar_pc_d = 1'b0;
        ack_d         = 1'b0;
        atual_d       = atual_q;
        sem_d         = sem_q;
        ocupado_d     = ocupado_q;
`ifdef ESCALONADOR_CONTA_TROCAS_EN
        trocas_d      = trocas_q;
`endif

        case (estado_q)
            IDLE: begin
                if (evento) begin
                    // With the OS running there is no process to save or finish
                    if (!sem_q) begin
                        estado_d  = SALVA;
                        ocupado_d = 1'b1;
                        eh_fim_d  = fim_sobe;
                    end
                end else if (carregar_req) begin
                    valid_d[carregar_pid]  = 1'b1;
                    pc_tab_d[carregar_pid] = carregar_pc_in;
                    ack_d                  = 1'b1;
                    // Dispatch the new process immediately if only the OS was running
                    if (sem_q) begin
                        estado_d  = BUSCA;
                        idx_d     = carregar_pid;
                        cnt_d     = '0;
                        ocupado_d = 1'b1;
                    end
                end
            end
            SALVA: begin
                if (eh_fim_q) begin
                    valid_d[atual_q] = 1'b0;
                end else begin
                    pc_tab_d[atual_q] = pc_processo_trocado;
                end
                idx_d    = atual_q + IDX_W'(1);
                cnt_d    = '0;
                estado_d = BUSCA;
            end
            BUSCA: begin
                if (valid_q[idx_q]) begin
                    sel_d    = idx_q;
                    achou_d  = 1'b1;
                    estado_d = CARREGA;
                end else if (cnt_q == IDX_W'(NUM_PROC - 1)) begin
                    achou_d  = 1'b0;
                    estado_d = CARREGA;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            CARREGA: begin
                carregar_pc_d = 1'b1;
                ocupado_d     = 1'b0;
                estado_d      = IDLE;
                if (achou_q) begin
                    pc_novo_d = pc_tab_q[sel_q];
                    atual_d   = sel_q;
                    sem_d     = 1'b0;
`ifdef ESCALONADOR_CONTA_TROCAS_EN
                    if (trocas_q != 32'hFFFF_FFFF) begin
                        trocas_d = trocas_q + 32'd1;
                    end
`endif
                end else begin
                    pc_novo_d = SO_PC;
                    sem_d     = 1'b1;
                end
            end
            default: estado_d = IDLE;
        endcase
    end

    // State and table registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q      <= IDLE;
            troca_q       <= 1'b0;
            fim_q         <= 1'b0;
            eh_fim_q      <= 1'b0;
            idx_q         <= '0;
            cnt_q         <= '0;
            sel_q         <= '0;
            achou_q       <= 1'b0;
            valid_q       <= '0;
            for (int i = 0; i < NUM_PROC; i++) begin
                pc_tab_q[i] <= '0;
            end
            pc_novo_q     <= SO_PC;
            carregar_pc_q <= 1'b0;
            ack_q         <= 1'b0;
            atual_q       <= '0;
            sem_q         <= 1'b1;
            ocupado_q     <= 1'b0;
`ifdef ESCALONADOR_CONTA_TROCAS_EN
            trocas_q      <= '0;
`endif
        end else begin
            estado_q      <= estado_d;
            troca_q       <= troca_contexto;
            fim_q         <= fimProcesso;
            eh_fim_q      <= eh_fim_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            sel_q         <= sel_d;
            achou_q       <= achou_d;
            valid_q       <= valid_d;
            pc_tab_q      <= pc_tab_d;
            pc_novo_q     <= pc_novo_d;
            carregar_pc_q <= carregar_pc_d;
            ack_q         <= ack_d;
            atual_q       <= atual_d;
            sem_q         <= sem_d;
            ocupado_q     <= ocupado_d;
`ifdef ESCALONADOR_CONTA_TROCAS_EN
            trocas_q      <= trocas_d;
`endif
        end
    end

    assign carregar_ack   = ack_q;
    assign pc_novo        = pc_novo_q;
    assign carregar_pc    = carregar_pc_q;
    assign processo_atual = atual_q;
    assign sem_processo   = sem_q;
    assign ocupado        = ocupado_q;
`ifdef ESCALONADOR_CONTA_TROCAS_EN
    assign total_trocas   = trocas_q;
`endif

endmodule

// File: tb/tb_escalonador_processos.sv
// Testbench for escalonador_processos: random OS loads, context switches and
// process completions against a process-table reference model; dispatches are
// queued as expectations and checked by an independent monitor.
module tb_escalonador_processos;

    localparam int N  = 4;
    localparam int PW = 32;
    localparam logic [PW-1:0] SO = 32'd0;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          troca_contexto = 1'b0;
    logic [PW-1:0] pc_processo_trocado = '0;
    logic          fimProcesso = 1'b0;
    logic          carregar_req = 1'b0;
    logic [1:0]    carregar_pid = '0;
    logic [PW-1:0] carregar_pc_in = '0;
    logic          carregar_ack;
    logic [PW-1:0] pc_novo;
    logic          carregar_pc;
    logic [1:0]    processo_atual;
    logic          sem_processo;
    logic          ocupado;
`ifdef ESCALONADOR_CONTA_TROCAS_EN
    logic [31:0]   total_trocas;
`endif

    escalonador_processos #(.NUM_PROC(N), .PC_WIDTH(PW), .SO_PC(SO)) dut (
`ifdef ESCALONADOR_CONTA_TROCAS_EN
        .total_trocas        (total_trocas),
`endif
        .clock               (clock),
        .reset               (reset),
        .troca_contexto      (troca_contexto),
        .pc_processo_trocado (pc_processo_trocado),
        .fimProcesso         (fimProcesso),
        .carregar_req        (carregar_req),
        .carregar_pid        (carregar_pid),
        .carregar_pc_in      (carregar_pc_in),
        .carregar_ack        (carregar_ack),
        .pc_novo             (pc_novo),
        .carregar_pc         (carregar_pc),
        .processo_atual      (processo_atual),
        .sem_processo        (sem_processo),
        .ocupado             (ocupado)
    );

    always #5 clock = ~clock;

    longint cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        longint pc;
        longint pid;
        longint sem;
        longint cyc;     // expected sampling cycle of the pulse, -1 = not checked
        longint trocas;
    } exp_t;

    exp_t exp_q[$];
    int   ack_exp = 0;

    // Reference model: the process table as plain arrays
    bit          m_valid [N];
    logic [31:0] m_pc    [N];
    int          m_cur;
    bit          m_sem;
    longint      m_trocas;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_pc[i]    = '0;
        end
        m_cur = 0; m_sem = 1'b1; m_trocas = 0;
    endtask

    // Next ready process after the current one, current one last
    task automatic model_event(input bit fim, input logic [31:0] spc, input longint c);
        exp_t e;
        int   found;
        int   kk;
        if (m_sem) return;
        if (fim) m_valid[m_cur] = 1'b0;
        else     m_pc[m_cur] = spc;
        found = -1; kk = N;
        for (int k = 1; k <= N; k++) begin
            if (found < 0 && m_valid[(m_cur + k) % N]) begin
                found = (m_cur + k) % N;
                kk = k;
            end
        end
        if (found >= 0) begin
            m_cur = found; m_sem = 1'b0; m_trocas++;
            e.pc = longint'(m_pc[found]); e.sem = 0;
        end else begin
            m_sem = 1'b1;
            e.pc = longint'(SO); e.sem = 1;
        end
        e.pid = m_cur;
        e.cyc = (c < 0) ? -1 : c + 3 + kk;
        e.trocas = m_trocas;
        exp_q.push_back(e);
    endtask

    task automatic model_load(input int pid, input logic [31:0] pc, input longint exp_cyc);
        exp_t e;
        m_valid[pid] = 1'b1;
        m_pc[pid]    = pc;
        if (m_sem) begin
            m_cur = pid; m_sem = 1'b0; m_trocas++;
            e.pc = longint'(pc); e.pid = pid; e.sem = 0;
            e.cyc = exp_cyc; e.trocas = m_trocas;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: every carregar_pc pulse must match the oldest expectation
    always @(negedge clock) begin
        if (reset) begin
            if (carregar_pc) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious carregar_pc: pc_novo=%0d processo_atual=%0d, no dispatch expected",
                             pc_novo, processo_atual);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("pc_novo", longint'(pc_novo), e.pc);
                    chk("processo_atual", longint'(processo_atual), e.pid);
                    chk("sem_processo", longint'(sem_processo), e.sem);
                    chk("ocupado at dispatch", longint'(ocupado), 0);
                    if (e.cyc >= 0) chk("dispatch latency cycle", cyc, e.cyc);
`ifdef ESCALONADOR_CONTA_TROCAS_EN
                    chk("total_trocas", longint'(total_trocas), e.trocas);
`endif
                end
            end
            if (carregar_ack) begin
                if (ack_exp == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious carregar_ack: ack seen with no load outstanding");
                end else begin
                    ack_exp--;
                end
            end
        end
    end

    task automatic wait_idle();
        for (int t = 0; t < 40; t++) begin
            @(negedge clock);
            if (exp_q.size() == 0 && !ocupado) break;
        end
        chk("dispatch pending after timeout", exp_q.size(), 0);
        repeat (N + 3) @(negedge clock);
    endtask

    task automatic do_load(input int pid, input logic [31:0] pc);
        longint c;
        bit     got;
        c = cyc;
        carregar_req = 1'b1; carregar_pid = 2'(pid); carregar_pc_in = pc;
        ack_exp++;
        model_load(pid, pc, c + 3);
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clock);
            if (carregar_ack) got = 1'b1;
        end
        chk("carregar_ack seen", longint'(got), 1);
        chk("carregar_ack latency", cyc - c, 1);
        carregar_req = 1'b0;
        wait_idle();
    endtask

    task automatic do_event(input bit tr, input bit fm, input logic [31:0] spc, input int hold);
        longint c;
        bit     was_sem;
        c = cyc;
        was_sem = m_sem;
        troca_contexto = tr; fimProcesso = fm; pc_processo_trocado = spc;
        model_event(fm, spc, c);
        @(negedge clock);
        chk("ocupado after event", longint'(ocupado), was_sem ? 0 : 1);
        repeat (hold - 1) @(negedge clock);
        troca_contexto = 1'b0; fimProcesso = 1'b0;
        wait_idle();
    endtask

    // troca + fim together while a load request is waiting
    task automatic do_combined(input int pid, input logic [31:0] pc, input logic [31:0] spc);
        longint c;
        bit     got;
        c = cyc;
        troca_contexto = 1'b1; fimProcesso = 1'b1; pc_processo_trocado = spc;
        carregar_req = 1'b1; carregar_pid = 2'(pid); carregar_pc_in = pc;
        model_event(1'b1, spc, c);
        ack_exp++;
        model_load(pid, pc, -1);
        @(negedge clock);
        chk("no ack in event cycle", longint'(carregar_ack), 0);
        troca_contexto = 1'b0; fimProcesso = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 60 && !got; t++) begin
            if (carregar_ack) got = 1'b1;
            else @(negedge clock);
        end
        chk("deferred carregar_ack seen", longint'(got), 1);
        carregar_req = 1'b0;
        wait_idle();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " pc_novo"}, longint'(pc_novo), longint'(SO));
        chk({tag, " carregar_pc"}, longint'(carregar_pc), 0);
        chk({tag, " carregar_ack"}, longint'(carregar_ack), 0);
        chk({tag, " processo_atual"}, longint'(processo_atual), 0);
        chk({tag, " sem_processo"}, longint'(sem_processo), 1);
        chk({tag, " ocupado"}, longint'(ocupado), 0);
`ifdef ESCALONADOR_CONTA_TROCAS_EN
        chk({tag, " total_trocas"}, longint'(total_trocas), 0);
`endif
    endtask

    initial begin
        #200_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clock);
        chk_reset_outputs("reset");
        reset = 1'b1;
        @(negedge clock);

        // Directed scenario
        do_load(0, 32'd400);
        do_load(1, 32'd500);
        do_event(1'b1, 1'b0, 32'd412, 3);
        do_event(1'b0, 1'b1, 32'd0, 1);
        do_event(1'b0, 1'b1, 32'd0, 1);
        chk("sem_processo after last process", longint'(sem_processo), 1);
        do_event(1'b1, 1'b0, 32'd999, 1);
        do_load(2, 32'd600);
        do_load(3, 32'd700);
        do_combined(1, 32'd800, 32'd1234);

        // Randomised traffic
        for (int n = 0; n < 150; n++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op < 4)
                do_load($urandom_range(0, N - 1), $urandom & 32'h0000_FFFC);
            else if (op < 7)
                do_event(1'b1, 1'b0, $urandom & 32'h0000_FFFC, $urandom_range(1, 3));
            else if (op < 9)
                do_event(1'b0, 1'b1, 32'd0, $urandom_range(1, 2));
            else
                do_combined($urandom_range(0, N - 1), $urandom & 32'h0000_FFFC,
                            $urandom & 32'h0000_FFFC);
        end

        // Asynchronous reset while scanning
        if (m_sem) do_load(0, 32'd44);
        troca_contexto = 1'b1; pc_processo_trocado = 32'd77;
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
        #1 chk_reset_outputs("async reset");
        exp_q.delete();
        model_reset();
        troca_contexto = 1'b0;
        repeat (4) @(negedge clock);
        chk("carregar_pc held in reset", longint'(carregar_pc), 0);
        reset = 1'b1;
        @(negedge clock);
        do_load(1, 32'd123);

        chk("expectations left", exp_q.size(), 0);
        chk("acks outstanding", ack_exp, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/escalonador_processos.md
Name: escalonador_processos

Overview:
Round-robin context-switch controller directly downstream of the quantum counter. Consumes troca_contexto, pc_processo_trocado and fimProcesso, saves the interrupted PC into an internal process table, selects the next ready process, and drives the new PC into the PC register. The OS loads process entries through a simple request/ack port.

Parameters:
NUM_PROC, 4, number of process-table entries (power of 2, >=2)
PC_WIDTH, 32, PC width
SO_PC, 32'd0, PC issued when no process is ready (OS entry)

Ports:
clock  in  1  system clock, posedge
reset  in  1  asynchronous, active-low; clears all state
troca_contexto  in  1  quantum-expired flag from quantum counter (level, may stay high several cycles)
pc_processo_trocado  in  PC_WIDTH  resume PC of interrupted process
fimProcesso  in  1  current process finished (level)
carregar_req  in  1  OS request to write a table entry
carregar_pid  in  log2(NUM_PROC)  entry index to write
carregar_pc_in  in  PC_WIDTH  start PC for that entry
carregar_ack  out  1  one-cycle pulse: write accepted
pc_novo  out  PC_WIDTH  PC to load into PC register
carregar_pc  out  1  one-cycle pulse: PC register must load pc_novo
processo_atual  out  log2(NUM_PROC)  index of running process
sem_processo  out  1  no ready process; pc_novo = SO_PC
ocupado  out  1  switch in progress

Behaviour:
- Reset (reset=0, async): all valid bits 0, stored PCs 0, state IDLE, pc_novo=SO_PC, carregar_pc=0, carregar_ack=0, processo_atual=0, sem_processo=1, ocupado=0, edge registers 0.
- Event detection: rising edge of troca_contexto (registered previous value) or rising edge of fimProcesso; levels held high do not retrigger.
- States: IDLE, SALVA, BUSCA, CARREGA.
- IDLE: event sampled at edge E0 -> SALVA, ocupado=1 from E0. If both edges occur together, fimProcesso wins (no save).
- SALVA (edge E1): troca -> table[processo_atual].pc <= pc_processo_trocado, valid stays 1; fim -> table[processo_atual].valid <= 0. Scan index <= processo_atual+1 (mod NUM_PROC). -> BUSCA.
- BUSCA: one candidate per edge, starting E2. Valid -> CARREGA with sel=candidate. Otherwise index+1 mod NUM_PROC. Scan covers NUM_PROC candidates, last one = processo_atual itself (a sole ready process resumes itself). All invalid after NUM_PROC checks -> CARREGA with no selection.
- CARREGA (edge after the hit): pc_novo <= table[sel].pc, processo_atual <= sel, sem_processo <= 0; if none: pc_novo <= SO_PC, sem_processo <= 1, processo_atual unchanged. carregar_pc=1 for exactly one cycle; ocupado=0; -> IDLE.
- Latency: next neighbour valid -> carregar_pc high in cycle after E3; worst case after E(2+NUM_PROC).
- Events while ocupado=1 are dropped; edge registers still track inputs.
- Event arriving while sem_processo=1 (OS running): troca ignored (nothing to save); fim ignored.
- Load port: accepted only in IDLE with no event that cycle; on accept, table[pid] <= {valid=1, pc=carregar_pc_in}, carregar_ack pulses next cycle. Otherwise no ack; requester holds carregar_req until ack. Writing the running pid overwrites its stored PC.
- Accepted load while sem_processo=1 triggers selection (direct to BUSCA starting at carregar_pid) so the new process is dispatched without OS polling.
- Index arithmetic is log2(NUM_PROC) bits, naturally wrapping.

Optional Feature:
ESCALONADOR_CONTA_TROCAS_EN: defined -> extra output total_trocas [31:0], reset 0, +1 on every carregar_pc pulse that selects a process (not on SO_PC dispatch), saturates at 32'hFFFFFFFF. Undefined -> port and counter absent; all other behaviour identical.

Test Plan:
- Reset low mid-BUSCA -> all outputs at reset values immediately, pc_novo=0, sem_processo=1, no carregar_pc pulse.
- Load pid0 PC=400, pid1 PC=500 -> two carregar_ack pulses; dispatch of pid0: carregar_pc pulse, pc_novo=400, processo_atual=0, sem_processo=0.
- Running pid0, troca_contexto held high 3 cycles with pc_processo_trocado=412 -> single switch, pc_novo=500, processo_atual=1 in cycle after E3; table[0].pc=412.
- Running pid1, fimProcesso rises, only pid0 valid -> pid1 invalidated, pc_novo=412, processo_atual=0.
- Running pid0 sole valid, fimProcesso -> after NUM_PROC scans pc_novo=SO_PC, sem_processo=1; subsequent troca pulse ignored.
- troca and fimProcesso rising same cycle with carregar_req high -> no ack, fim path taken, stored PC not updated; ack after returning to IDLE.
